if_stage: RTL

Instruction-fetch stage of the in-order RISC-V pipeline. It owns the program counter, fetches instructions from instruction memory over a request/grant/response handshake, and drives the IF/ID pipeline register as the master of `IF2ID_if`; the decode stage is the slave. It handles stalls from the hazard unit, bubble insertion on flush, and PC redirects from branches and jumps resolved in EX.

---
 rtl/core_pkg.sv | 16 +
 rtl/IF2ID_if.sv | 7 +
 rtl/if_stage.sv | 82 ++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the in-order RISC-V pipeline.
package core_pkg;
    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] instruction;
    } if_id_data_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} if_state_e;

    localparam if_id_data_t BUBBLE = '{pc: '0, pc_plus4: '0, instruction: NOP_INSTR};
endpackage

// File: rtl/IF2ID_if.sv
// IF2ID_if: IF/ID pipeline register contents, driven by fetch and read by decode.
interface IF2ID_if;
    import core_pkg::*;
    if_id_data_t data;
    modport MASTER (output data);
    modport SLAVE  (input  data);
endinterface

// File: rtl/if_stage.sv
// if_stage: PC, instruction fetch over req/gnt/rvalid, and the IF/ID register.
module if_stage
    import core_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    IF2ID_if.MASTER               bus_out
);
    if_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_next;
    logic                  discard_q, discard_d;
    if_id_data_t           hold_q, hold_d, if_id_q, if_id_d, fetched;
    logic                  resp, accept, capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            hold_q    <= BUBBLE;
            if_id_q   <= BUBBLE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            hold_q    <= hold_d;
            if_id_q   <= if_id_d;
        end
    end

    // A response only counts when it is not stale and no redirect overrides it.
    always_comb begin
        pc_next     = pc_q + 32'd4;
        resp        = state_q == WAIT && imem_rvalid_i && !discard_q && !redirect_i;
        accept      = resp && !stall_i;
        capture     = resp && stall_i;
        fetched     = '{pc: pc_q, pc_plus4: pc_next, instruction: imem_rdata_i};
        imem_req_o  = state_q == REQ || accept;
        imem_addr_o = accept ? pc_next : (state_q == REQ && redirect_i) ? redirect_pc_i : pc_q;
        pc_d        = redirect_i ? redirect_pc_i : (accept || capture) ? pc_next : pc_q;
        hold_d      = redirect_i ? BUBBLE : capture ? fetched : hold_q;
        if_id_d     = (redirect_i || flush_i) ? BUBBLE :
                      accept ? fetched :
                      (state_q == HOLD && !stall_i) ? hold_q : if_id_q;
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                state_d   = imem_gnt_i ? WAIT : REQ;
                discard_d = redirect_i && imem_gnt_i;
            end
            WAIT: begin
                if (redirect_i) begin
                    state_d   = imem_rvalid_i ? REQ : WAIT;
                    discard_d = !imem_rvalid_i;
                end else if (imem_rvalid_i) begin
                    state_d   = discard_q ? REQ : stall_i ? HOLD : imem_gnt_i ? WAIT : REQ;
                    discard_d = 1'b0;
                end
            end
            HOLD: state_d = (redirect_i || !stall_i) ? REQ : HOLD;
            default: state_d = IDLE;
        endcase
    end

    assign bus_out.data = if_id_q;
endmodule
